// File: rtl/prog_loader_if.sv
// Host-link byte stream and instruction-memory write port of the program loader.
// The loader side uses the slave modport; the host/memory side uses master.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: A5, COUNT_H, COUNT_L, N 16-bit words (high byte
// first), XOR checksum. Writes words to instruction memory and releases the CPU on success.
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    prog_loader_if.slave    bus,
    output logic            cpu_reset,
    output logic            done,
    output logic            error
);
    typedef enum logic [2:0] {
        IDLE,
        CNT_H,
        CNT_L,
        BYTE_H,
        BYTE_L,
        CHECK,
        RUN,
        ERR
    } state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [16:0] MAX_COUNT = 17'(1) << ADDR_W;

    state_t            state_reg;
    logic [15:0]       count_reg;
    logic [ADDR_W:0]   ptr_reg;
    logic [7:0]        chk_reg;
    logic [7:0]        hi_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [15:0]       mem_wdata_reg;
    logic              cpu_reset_reg;
    logic              done_reg;
    logic              error_reg;

    logic              accept;
    logic [15:0]       count_next;
    logic [15:0]       ptr_inc;

    // The loader never back-pressures; unused bytes are simply swallowed.
    assign bus.rx_ready = 1'b1;
    assign accept       = bus.rx_valid & bus.rx_ready;
    assign count_next   = {count_reg[15:8], bus.rx_data};
    assign ptr_inc      = 16'(ptr_reg) + 16'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            ptr_reg       <= '0;
            chk_reg       <= '0;
            hi_reg        <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cpu_reset_reg <= 1'b1;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            mem_we_reg <= 1'b0;
            if (accept) begin
                case (state_reg)
                    IDLE: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            state_reg <= CNT_H;
                        end
                    end
                    CNT_H: begin
                        count_reg[15:8] <= bus.rx_data;
                        state_reg       <= CNT_L;
                    end
                    CNT_L: begin
                        count_reg <= count_next;
                        // 17-bit compare so a full 2^ADDR_W-word image is still legal.
                        if (count_next == 16'd0 || 17'(count_next) > MAX_COUNT) begin
                            error_reg <= 1'b1;
                            state_reg <= ERR;
                        end else begin
                            ptr_reg   <= '0;
                            chk_reg   <= '0;
                            state_reg <= BYTE_H;
                        end
                    end
                    BYTE_H: begin
                        hi_reg    <= bus.rx_data;
                        chk_reg   <= chk_reg ^ bus.rx_data;
                        state_reg <= BYTE_L;
                    end
                    BYTE_L: begin
                        chk_reg       <= chk_reg ^ bus.rx_data;
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= ptr_reg[ADDR_W-1:0];
                        mem_wdata_reg <= {hi_reg, bus.rx_data};
                        ptr_reg       <= ptr_reg + 1'b1;
                        state_reg     <= (ptr_inc == count_reg) ? CHECK : BYTE_H;
                    end
                    CHECK: begin
                        if (bus.rx_data == chk_reg) begin
                            cpu_reset_reg <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= RUN;
                        end else begin
                            error_reg <= 1'b1;
                            state_reg <= ERR;
                        end
                    end
                    RUN: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            cpu_reset_reg <= 1'b1;
                            done_reg      <= 1'b0;
                            state_reg     <= CNT_H;
                        end
                    end
                    ERR: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            error_reg <= 1'b0;
                            state_reg <= CNT_H;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign cpu_reset     = cpu_reset_reg;
    assign done          = done_reg;
    assign error         = error_reg;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, checksum/count errors, gaps, reload, reset.
module tb_prog_loader;
    localparam int ADDR_W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cpu_reset;
    logic done;
    logic error;

    prog_loader_if #(.ADDR_W(ADDR_W)) lif ();

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (lif),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] frame_q[$];
    logic [7:0] chk_acc;
    int         wr_addr_q[$];
    int         wr_data_q[$];
    logic       prev_we = 1'b0;
    int         double_we = 0;

    // Write monitor: records every strobe and flags any strobe wider than one cycle.
    always @(negedge clock) begin
        if (lif.mem_we) begin
            wr_addr_q.push_back(int'(lif.mem_addr));
            wr_data_q.push_back(int'(lif.mem_wdata));
            if (prev_we) double_we++;
        end
        prev_we = lif.mem_we;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        lif.rx_valid = 1'b1;
        lif.rx_data  = b;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        lif.rx_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] count);
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(count[15:8]);
        frame_q.push_back(count[7:0]);
        chk_acc = 8'h00;
    endtask

    task automatic push_word(input logic [15:0] w);
        frame_q.push_back(w[15:8]);
        frame_q.push_back(w[7:0]);
        chk_acc = chk_acc ^ w[15:8] ^ w[7:0];
    endtask

    task automatic send_q(input bit gaps);
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i]);
            if (gaps && i < frame_q.size() - 1) idle($urandom_range(0, 3));
        end
        lif.rx_valid = 1'b0;
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_two_word_image(input string tag);
        check({tag, "_wr_count"}, wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check({tag, "_addr0"}, wr_addr_q[0], 0);
            check({tag, "_data0"}, wr_data_q[0], 32'h1234);
            check({tag, "_addr1"}, wr_addr_q[1], 1);
            check({tag, "_data1"}, wr_data_q[1], 32'hABCD);
        end
    endtask

    initial begin
        lif.rx_valid = 1'b0;
        lif.rx_data  = 8'h00;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst_rx_ready", lif.rx_ready, 1);
        check("rst_mem_we", lif.mem_we, 0);
        check("rst_mem_addr", lif.mem_addr, 0);
        check("rst_mem_wdata", lif.mem_wdata, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b0;
        idle(1);

        // Two-word load, back-to-back bytes
        clear_writes();
        start_frame(16'd2);
        push_word(16'h1234);
        push_word(16'hABCD);
        send_q(1'b0);
        check("l2_we_pulse", lif.mem_we, 1);
        check("l2_we_addr", lif.mem_addr, 1);
        check("l2_we_data", lif.mem_wdata, 32'hABCD);
        check("l2_done_before_chk", done, 0);
        check("l2_cpurst_before_chk", cpu_reset, 1);
        send_byte(8'h40);
        lif.rx_valid = 1'b0;
        check("l2_done", done, 1);
        check("l2_cpu_reset", cpu_reset, 0);
        check("l2_error", error, 0);
        check("l2_we_low", lif.mem_we, 0);
        check("l2_addr_hold", lif.mem_addr, 1);
        check("l2_data_hold", lif.mem_wdata, 32'hABCD);
        idle(2);
        check_two_word_image("l2");
        $display("frame: 2-word load, chk=40, done=%0d cpu_reset=%0d", done, cpu_reset);

        // Bad checksum, restarting from RUN
        clear_writes();
        send_byte(8'hA5);
        lif.rx_valid = 1'b0;
        check("bad_restart_cpurst", cpu_reset, 1);
        check("bad_restart_done", done, 0);
        frame_q.delete();
        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_q(1'b0);
        check("bad_error", error, 1);
        check("bad_cpu_reset", cpu_reset, 1);
        check("bad_done", done, 0);
        idle(2);
        check_two_word_image("bad");
        $display("frame: 2-word load, chk=41, error=%0d", error);

        // Count zero
        send_byte(8'hA5);
        lif.rx_valid = 1'b0;
        check("cnt0_error_cleared", error, 0);
        frame_q = '{8'h00, 8'h00};
        send_q(1'b0);
        check("cnt0_error", error, 1);
        check("cnt0_cpu_reset", cpu_reset, 1);
        $display("frame: count=0000, error=%0d", error);

        // Count 257
        frame_q = '{8'hA5, 8'h01};
        send_q(1'b0);
        check("cnt257_error_mid", error, 0);
        send_byte(8'h01);
        lif.rx_valid = 1'b0;
        check("cnt257_error", error, 1);
        $display("frame: count=0101, error=%0d", error);

        // Full 256-word image
        clear_writes();
        start_frame(16'h0100);
        for (int i = 0; i < 256; i++) push_word({8'(i), 8'(i * 3 + 1)});
        frame_q.push_back(chk_acc);
        send_q(1'b0);
        check("full_done", done, 1);
        check("full_error", error, 0);
        check("full_cpu_reset", cpu_reset, 0);
        idle(2);
        check("full_wr_count", wr_addr_q.size(), 256);
        if (wr_addr_q.size() == 256) begin
            check("full_last_addr", wr_addr_q[255], 32'hFF);
            check("full_last_data", wr_data_q[255], 32'hFFFE);
            check("full_mid_addr", wr_addr_q[100], 100);
            check("full_mid_data", wr_data_q[100], 32'h642D);
        end
        $display("frame: count=0100, writes=%0d done=%0d", wr_addr_q.size(), done);

        // Reload one word
        clear_writes();
        send_byte(8'hA5);
        check("reload_cpurst", cpu_reset, 1);
        check("reload_done_low", done, 0);
        frame_q = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00};
        send_q(1'b0);
        check("reload_done", done, 1);
        check("reload_cpu_reset", cpu_reset, 0);
        idle(2);
        check("reload_wr_count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("reload_addr", wr_addr_q[0], 0);
            check("reload_data", wr_data_q[0], 32'hFFFF);
        end
        $display("frame: reload 1 word FFFF, done=%0d", done);

        // Reset mid-frame, coinciding with a BYTE_L accept
        clear_writes();
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
        send_q(1'b0);
        send_byte(8'hAB);
        lif.rx_data = 8'hCD;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        lif.rx_valid = 1'b0;
        check("mid_rst_mem_we", lif.mem_we, 0);
        check("mid_rst_mem_addr", lif.mem_addr, 0);
        check("mid_rst_mem_wdata", lif.mem_wdata, 0);
        check("mid_rst_cpu_reset", cpu_reset, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_error", error, 0);
        idle(2);
        check("mid_rst_wr_count", wr_addr_q.size(), 1);
        clear_writes();
        start_frame(16'd2);
        push_word(16'h1122);
        push_word(16'h3344);
        frame_q.push_back(8'h44);
        send_q(1'b0);
        check("post_rst_done", done, 1);
        idle(2);
        check("post_rst_wr_count", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check("post_rst_data0", wr_data_q[0], 32'h1122);
            check("post_rst_addr1", wr_addr_q[1], 1);
            check("post_rst_data1", wr_data_q[1], 32'h3344);
        end
        $display("frame: reset mid-frame then 2-word load, done=%0d", done);

        // Noise before sync and random gaps inside the frame
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        clear_writes();
        frame_q = '{8'h00, 8'hFF, 8'h5A};
        send_q(1'b1);
        check("noise_done", done, 0);
        check("noise_error", error, 0);
        start_frame(16'd2);
        push_word(16'h1234);
        push_word(16'hABCD);
        frame_q.push_back(8'h40);
        send_q(1'b1);
        check("gap_done", done, 1);
        check("gap_cpu_reset", cpu_reset, 0);
        idle(2);
        check_two_word_image("gap");
        $display("frame: noise + gapped 2-word load, done=%0d", done);

        check("we_single_cycle", double_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
